// File: rtl/gate_sweep_pkg.sv
// Shared types and helpers for the AND-gate sweep controller.
// Optional build macro: SWEEP_STOP_ON_FAIL_EN (stop at first mismatch).
package gate_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        DONE
    } sweep_state_e;

    function automatic int vec_w(input int n);
        return n;
    endfunction

    function automatic int err_w(input int n);
        return n + 1;
    endfunction

    // Bits at or above n are outside the gate and must not affect the result.
    function automatic logic and_ref(input logic [7:0] vec, input int n);
        logic r;
        r = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i < n) r = r & vec[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/gate_sweep_checker.sv
// CHECK-phase compare against the AND reference, mismatch counter
// and first-failing-vector capture.
module gate_sweep_checker
    import gate_sweep_pkg::*;
#(
    parameter int N_INPUTS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                check_en,
    input  logic [N_INPUTS-1:0] vec,
    input  logic                gate_y,
    output logic                mismatch,
    output logic [N_INPUTS:0]   err_count,
    output logic                fail_valid,
    output logic [N_INPUTS-1:0] first_fail_vec
);

    localparam int EW = err_w(N_INPUTS);

    logic [EW-1:0]       err_count_q, err_count_d;
    logic                fail_valid_q, fail_valid_d;
    logic [N_INPUTS-1:0] first_fail_vec_q, first_fail_vec_d;

    // Case inequality so an X from the gate is scored as a failure.
    assign mismatch = (gate_y !== and_ref(8'(vec), N_INPUTS));

    always_comb begin
        err_count_d      = err_count_q;
        fail_valid_d     = fail_valid_q;
        first_fail_vec_d = first_fail_vec_q;
        if (clear) begin
            err_count_d      = '0;
            fail_valid_d     = 1'b0;
            first_fail_vec_d = '0;
        end else if (check_en && mismatch) begin
            err_count_d = err_count_q + EW'(1);
            if (!fail_valid_q) begin
                fail_valid_d     = 1'b1;
                first_fail_vec_d = vec;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_count_q      <= '0;
            fail_valid_q     <= 1'b0;
            first_fail_vec_q <= '0;
        end else begin
            err_count_q      <= err_count_d;
            fail_valid_q     <= fail_valid_d;
            first_fail_vec_q <= first_fail_vec_d;
        end
    end

    assign err_count      = err_count_q;
    assign fail_valid     = fail_valid_q;
    assign first_fail_vec = first_fail_vec_q;

endmodule

// File: rtl/and_gate_sweep_ctrl.sv
// Sweeps an N-input AND gate through every input vector and scores it.
// Define SWEEP_STOP_ON_FAIL_EN to end the sweep at the first mismatch.
module and_gate_sweep_ctrl
    import gate_sweep_pkg::*;
#(
    parameter int N_INPUTS      = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic                gate_y,
    output logic [N_INPUTS-1:0] drive_vec,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [N_INPUTS:0]   err_count,
    output logic                fail_valid,
    output logic [N_INPUTS-1:0] first_fail_vec
);

    localparam int VW = vec_w(N_INPUTS);
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);

    sweep_state_e state_q, state_d;

    logic [VW-1:0] vec_q, vec_d;
    logic [CW-1:0] settle_cnt_q, settle_cnt_d;
    logic [VW-1:0] drive_vec_q, drive_vec_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;

    logic          start_ok;
    logic          check_en;
    logic          mismatch;
    logic          stop_hit;
    logic          last_vec;
    logic          settle_done;

    assign start_ok    = start && !abort &&
                         (state_q == IDLE || state_q == DONE);
    assign check_en    = (state_q == CHECK) && !abort;
    assign last_vec    = (vec_q == '1);
    assign settle_done = (settle_cnt_q == SETTLE_LAST);

`ifdef SWEEP_STOP_ON_FAIL_EN
    assign stop_hit = mismatch;
`else
    assign stop_hit = 1'b0;
`endif

    gate_sweep_checker #(
        .N_INPUTS(N_INPUTS)
    ) u_checker (
        .clk           (clk),
        .rst           (rst),
        .clear         (start_ok),
        .check_en      (check_en),
        .vec           (vec_q),
        .gate_y        (gate_y),
        .mismatch      (mismatch),
        .err_count     (err_count),
        .fail_valid    (fail_valid),
        .first_fail_vec(first_fail_vec)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: if (start) state_d = SETTLE;
            SETTLE:     if (settle_done) state_d = CHECK;
            CHECK:      state_d = (last_vec || stop_hit) ? DONE : SETTLE;
            default:    state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    // done/pass land one edge after DONE is entered, once err_count has
    // absorbed the final check.
    always_comb begin
        vec_d        = vec_q;
        settle_cnt_d = settle_cnt_q;
        if (start_ok) begin
            vec_d        = '0;
            settle_cnt_d = '0;
        end else if (!abort) begin
            if (state_q == SETTLE) settle_cnt_d = settle_cnt_q + 1'b1;
            if (state_q == CHECK && state_d == SETTLE) begin
                vec_d        = vec_q + 1'b1;
                settle_cnt_d = '0;
            end
        end
        drive_vec_d = (state_d == IDLE) ? '0 : vec_d;
        busy_d      = (state_d == SETTLE) || (state_d == CHECK);
        done_d      = (state_q == DONE) && (state_d == DONE);
        pass_d      = done_d && (err_count == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec_q        <= '0;
            settle_cnt_q <= '0;
            drive_vec_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            vec_q        <= vec_d;
            settle_cnt_q <= settle_cnt_d;
            drive_vec_q  <= drive_vec_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
        end
    end

    assign drive_vec = drive_vec_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;

endmodule

// File: tb/tb_and_gate_sweep_ctrl.sv
// Self-checking bench: two controllers (N=2/S=1 and N=3/S=3) driving
// fault-injectable AND gate models, scored against an edge-count model.
module tb_and_gate_sweep_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic start2, abort2, start3, abort3;
    logic [7:0] fmask2, fmask3;

    logic [1:0] drive2;
    logic [2:0] drive3;
    logic       busy2, done2, pass2, fv2, y2;
    logic       busy3, done3, pass3, fv3, y3;
    logic [2:0] err2;
    logic [3:0] err3;
    logic [1:0] ff2;
    logic [2:0] ff3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Faulty gate: a set mask bit inverts the output for that vector.
    assign y2 = (&drive2) ^ fmask2[drive2];
    assign y3 = (&drive3) ^ fmask3[drive3];

    and_gate_sweep_ctrl #(.N_INPUTS(2), .SETTLE_CYCLES(1)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2),
        .gate_y(y2), .drive_vec(drive2), .busy(busy2), .done(done2),
        .pass(pass2), .err_count(err2), .fail_valid(fv2),
        .first_fail_vec(ff2)
    );

    and_gate_sweep_ctrl #(.N_INPUTS(3), .SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .abort(abort3),
        .gate_y(y3), .drive_vec(drive3), .busy(busy3), .done(done3),
        .pass(pass3), .err_count(err3), .fail_valid(fv3),
        .first_fail_vec(ff3)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h",
                     tag, $time, got, exp);
        end
    endtask

    task automatic sample(input bit w, output logic [7:0] drv,
                          output logic bz, output logic dn,
                          output logic ps, output logic [8:0] ec,
                          output logic fv, output logic [7:0] ff);
        if (w) begin
            drv = 8'(drive3); bz = busy3; dn = done3; ps = pass3;
            ec = 9'(err3); fv = fv3; ff = 8'(ff3);
        end else begin
            drv = 8'(drive2); bz = busy2; dn = done2; ps = pass2;
            ec = 9'(err2); fv = fv2; ff = 8'(ff2);
        end
    endtask

    task automatic chk_reset(input bit w);
        logic [7:0] drv, ff;
        logic bz, dn, ps, fv;
        logic [8:0] ec;
        sample(w, drv, bz, dn, ps, ec, fv, ff);
        chk($sformatf("rst%0d.drive", w), 32'(drv), 0);
        chk($sformatf("rst%0d.busy", w), 32'(bz), 0);
        chk($sformatf("rst%0d.done", w), 32'(dn), 0);
        chk($sformatf("rst%0d.pass", w), 32'(ps), 0);
        chk($sformatf("rst%0d.err", w), 32'(ec), 0);
        chk($sformatf("rst%0d.fv", w), 32'(fv), 0);
        chk($sformatf("rst%0d.ff", w), 32'(ff), 0);
    endtask

    task automatic set_in(input bit w, input logic s, input logic a);
        if (w) begin start3 = s; abort3 = a; end
        else   begin start2 = s; abort2 = a; end
    endtask

    // Edge 0 is the edge that samples start; vector k is checked on
    // edge (k+1)*(S+1); done rises one edge after the last check.
    task automatic sweep(input bit w, input logic [7:0] mask,
                         input int abort_in, input logic [63:0] pulses);
        int s, nv, last, done_edge, lim, cnt, ff_exp, end_n, abort_at;
        int ed;
        bit fv_exp, abrt;
        logic [7:0] drv, ff;
        logic bz, dn, ps, fv;
        logic [8:0] ec;
        s = w ? 3 : 1;
        nv = w ? 8 : 4;
        last = nv - 1;
`ifdef SWEEP_STOP_ON_FAIL_EN
        for (int k = nv - 1; k >= 0; k--) if (mask[k]) last = k;
`endif
        done_edge = (last + 1) * (s + 1) + 1;
        abort_at = abort_in;
        if (abort_at >= done_edge) abort_at = done_edge - 1;
        lim = (abort_at >= 0) ? abort_at : done_edge + 1;
        cnt = 0; ff_exp = 0; fv_exp = 0;
        for (int k = 0; k <= last; k++) begin
            if (mask[k] && (k + 1) * (s + 1) < lim) begin
                cnt++;
                if (!fv_exp) begin fv_exp = 1; ff_exp = k; end
            end
        end
        end_n = (abort_at >= 0) ? abort_at : done_edge;

        @(negedge clk);
        if (w) fmask3 = mask; else fmask2 = mask;
        set_in(w, 1'b1, 1'b0);
        @(posedge clk);
        for (int n = 0; n <= end_n; n++) begin
            @(negedge clk);
            sample(w, drv, bz, dn, ps, ec, fv, ff);
            abrt = (n == abort_at);
            ed = n / (s + 1);
            if (ed > last) ed = last;
            chk($sformatf("d%0d.drive.e%0d", w, n), 32'(drv),
                abrt ? 0 : ed);
            chk($sformatf("d%0d.busy.e%0d", w, n), 32'(bz),
                (!abrt && n < done_edge - 1) ? 1 : 0);
            chk($sformatf("d%0d.done.e%0d", w, n), 32'(dn),
                (!abrt && n >= done_edge) ? 1 : 0);
            chk($sformatf("d%0d.pass.e%0d", w, n), 32'(ps),
                (!abrt && n >= done_edge && cnt == 0) ? 1 : 0);
            if (n == 0) begin
                chk($sformatf("d%0d.errclr", w), 32'(ec), 0);
                chk($sformatf("d%0d.fvclr", w), 32'(fv), 0);
            end
            if (n == end_n) set_in(w, 1'b0, 1'b0);
            else begin
                set_in(w, pulses[n + 1], (n + 1 == abort_at));
                @(posedge clk);
            end
        end
        chk($sformatf("d%0d.err", w), 32'(ec), cnt);
        chk($sformatf("d%0d.fv", w), 32'(fv), fv_exp);
        chk($sformatf("d%0d.ff", w), 32'(ff), ff_exp);
    endtask

    initial begin
        bit rw;
        logic [7:0] rm;
        int ra;
        logic [7:0] drv, ff;
        logic bz, dn, ps, fv;
        logic [8:0] ec;

        rst = 1'b1;
        start2 = 0; abort2 = 0; start3 = 0; abort3 = 0;
        fmask2 = 0; fmask3 = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset(0);
        chk_reset(1);
        rst = 1'b0;

        sweep(0, 8'h00, -1, 64'h0);
        sweep(0, 8'h07, -1, 64'h0);
        sweep(0, 8'h01, 4, 64'h0);
        sweep(0, 8'h00, -1, 64'h0);
        sweep(0, 8'h00, -1, (64'h1 << 3) | (64'h1 << 5));
        sweep(0, 8'h02, -1, 64'h0);
        sweep(1, 8'h20, -1, 64'h0);

        @(negedge clk);
        start3 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_reset(0);
        chk_reset(1);
        rst = 1'b0;
        start3 = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            sample(1, drv, bz, dn, ps, ec, fv, ff);
            chk("t6.busy", 32'(bz), 0);
            chk("t6.done", 32'(dn), 0);
        end
        sweep(1, 8'h00, -1, 64'h0);

        for (int r = 0; r < 10; r++) begin
            rw = 1'($urandom);
            rm = 8'($urandom) & (rw ? 8'hff : 8'h0f);
            if ($urandom_range(0, 3) == 0) rm = 8'h00;
            ra = -1;
            if ($urandom_range(0, 2) == 0) ra = $urandom_range(1, 30);
            sweep(rw, rm, ra, 64'h0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
